// File: rtl/cpu_bus_sequencer.sv
// cpu_bus_sequencer: T-cycle sequencer and memory bus interface for the CPU core.
//
// Keeps a free-running 2-bit T-cycle count (T0..T3) that paces the microcoded
// control unit. It captures the per-M-cycle memory request at the end of T0 and
// drives the external address/data bus and strobes. Read data is latched into
// mem_data_in at the end of T2, so it is stable through T3.
//
// Ports:
//   clk          CPU clock, one T-cycle per rising edge
//   reset        synchronous reset, active-low
//   mem_enable   memory access requested this M-cycle (sampled in T0)
//   mem_write    access is a write (sampled in T0)
//   mem_addr     access address (sampled in T0)
//   mem_wdata    write data (sampled in T0)
//   t_cycle      current T-cycle 0..3
//   mcycle_last  high in T3
//   mem_data_in  last captured read data
//   bus_addr     external bus address
//   bus_wdata    external bus write data
//   bus_rd       external read strobe, T1..T2 of a read
//   bus_wr       external write strobe, T2 of a write
//   bus_rdata    external read data
//   bus_stall    T2 extension request from the bus holder
//
// Configuration:
//   CPU_BUS_STALL_EN  when defined, bus_stall holds an active M-cycle in T2.
//                     When it is undefined, bus_stall is ignored and every
//                     M-cycle takes exactly 4 clocks.
module cpu_bus_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic [1:0]  t_cycle,
    output logic        mcycle_last,
    output logic [7:0]  mem_data_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_stall
);
    typedef enum logic [1:0] {T0, T1, T2, T3} t_e;

    t_e          t_q, t_d;
    logic        req_en_q, req_en_d;
    logic        req_wr_q, req_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        last_q, last_d;
    logic        hold;
    logic        cap;

`ifdef CPU_BUS_STALL_EN
    assign hold = (t_q == T2) && req_en_q && bus_stall;
`else
    logic unused_stall;
    assign unused_stall = bus_stall;
    assign hold = 1'b0;
`endif

    always_comb begin
        cap      = (t_q == T0);
        t_d      = hold ? t_q : t_e'(t_q + 2'd1);
        req_en_d = cap ? mem_enable : req_en_q;
        req_wr_d = cap ? mem_write : req_wr_q;
        addr_d   = (cap && mem_enable) ? mem_addr : addr_q;
        wdata_d  = (cap && mem_enable) ? mem_wdata : wdata_q;
        rdata_d  = ((t_q == T2) && !hold && req_en_q && !req_wr_q) ? bus_rdata : rdata_q;
        // Strobes and mcycle_last are decoded from the next state, so they come straight from flops.
        rd_d     = req_en_d && !req_wr_d && ((t_d == T1) || (t_d == T2));
        wr_d     = req_en_d && req_wr_d && (t_d == T2);
        last_d   = (t_d == T3);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            t_q      <= T0;
            req_en_q <= 1'b0;
            req_wr_q <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            t_q      <= t_d;
            req_en_q <= req_en_d;
            req_wr_q <= req_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            last_q   <= last_d;
        end
    end

    assign t_cycle     = t_q;
    assign mcycle_last = last_q;
    assign mem_data_in = rdata_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_rd      = rd_q;
    assign bus_wr      = wr_q;
endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// tb_cpu_bus_sequencer: directed-vector self-checking bench for cpu_bus_sequencer.
module tb_cpu_bus_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_enable = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    logic [7:0]  mem_wdata = 8'h00;
    logic [1:0]  t_cycle;
    logic        mcycle_last;
    logic [7:0]  mem_data_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_stall = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    cpu_bus_sequencer dut (
        .clk(clk), .reset(reset), .mem_enable(mem_enable), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .t_cycle(t_cycle),
        .mcycle_last(mcycle_last), .mem_data_in(mem_data_in), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_rdata(bus_rdata), .bus_stall(bus_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_t", 32'(t_cycle), 0);
        chk("rst_last", 32'(mcycle_last), 0);
        chk("rst_rd", 32'(bus_rd), 0);
        chk("rst_wr", 32'(bus_wr), 0);
        chk("rst_addr", 32'(bus_addr), 0);
        chk("rst_wdata", 32'(bus_wdata), 0);
        chk("rst_mdi", 32'(mem_data_in), 0);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("cnt_t%0d", k), 32'(t_cycle), k % 4);
            chk($sformatf("cnt_last%0d", k), 32'(mcycle_last), 32'(k % 4 == 3));
        end
        repeat (3) tick();
        chk("t0_sync", 32'(t_cycle), 0);
        // Read of C123, with request inputs scrambled during T1..T3
        mem_enable = 1'b1; mem_write = 1'b0; mem_addr = 16'hC123; bus_rdata = 8'h5A;
        tick();
        chk("rd_t1_rd", 32'(bus_rd), 1);
        chk("rd_t1_wr", 32'(bus_wr), 0);
        chk("rd_t1_addr", 32'(bus_addr), 32'hC123);
        mem_enable = 1'b0; mem_addr = 16'h1234; mem_write = 1'b1;
        tick();
        chk("rd_t2_rd", 32'(bus_rd), 1);
        chk("rd_t2_addr", 32'(bus_addr), 32'hC123);
        tick();
        chk("rd_t3_rd", 32'(bus_rd), 0);
        chk("rd_t3_mdi", 32'(mem_data_in), 32'h5A);
        chk("rd_t3_last", 32'(mcycle_last), 1);
        bus_rdata = 8'h00;
        tick();
        chk("idle_t0_rd", 32'(bus_rd), 0);
        tick();
        chk("idle_t1_rd", 32'(bus_rd), 0);
        chk("idle_t1_wr", 32'(bus_wr), 0);
        chk("idle_addr", 32'(bus_addr), 32'hC123);
        tick();
        chk("idle_t2_rd", 32'(bus_rd), 0);
        tick();
        chk("idle_t3_mdi", 32'(mem_data_in), 32'h5A);
        tick();
        // Write of 91 to FF40
        mem_enable = 1'b1; mem_write = 1'b1; mem_addr = 16'hFF40; mem_wdata = 8'h91;
        tick();
        chk("wr_t1_wr", 32'(bus_wr), 0);
        chk("wr_t1_rd", 32'(bus_rd), 0);
        chk("wr_t1_addr", 32'(bus_addr), 32'hFF40);
        chk("wr_t1_wdata", 32'(bus_wdata), 32'h91);
        mem_wdata = 8'h33; mem_addr = 16'h0000; mem_write = 1'b0;
        tick();
        chk("wr_t2_wr", 32'(bus_wr), 1);
        chk("wr_t2_rd", 32'(bus_rd), 0);
        chk("wr_t2_wdata", 32'(bus_wdata), 32'h91);
        mem_enable = 1'b0;
        tick();
        chk("wr_t3_wr", 32'(bus_wr), 0);
        chk("wr_t3_wdata", 32'(bus_wdata), 32'h91);
        chk("wr_t3_mdi", 32'(mem_data_in), 32'h5A);
        tick();
        chk("wr_next_t0", 32'(t_cycle), 0);
        // Stall on a read of 2000
        mem_enable = 1'b1; mem_write = 1'b0; mem_addr = 16'h2000; bus_rdata = 8'h11;
        tick();
        mem_enable = 1'b0;
        tick();
        chk("st_t2", 32'(t_cycle), 2);
        bus_stall = 1'b1;
`ifdef CPU_BUS_STALL_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("st_hold_t%0d", k), 32'(t_cycle), 2);
            chk($sformatf("st_hold_rd%0d", k), 32'(bus_rd), 1);
            chk($sformatf("st_hold_mdi%0d", k), 32'(mem_data_in), 32'h5A);
        end
        bus_rdata = 8'h77; bus_stall = 1'b0;
        tick();
        chk("st_rel_t", 32'(t_cycle), 3);
        chk("st_rel_mdi", 32'(mem_data_in), 32'h77);
        chk("st_rel_rd", 32'(bus_rd), 0);
        tick();
`else
        tick();
        chk("nst_t3", 32'(t_cycle), 3);
        chk("nst_mdi", 32'(mem_data_in), 32'h11);
        tick();
        chk("nst_t0", 32'(t_cycle), 0);
        tick();
        chk("nst_t1", 32'(t_cycle), 1);
        chk("nst_rd", 32'(bus_rd), 0);
        bus_rdata = 8'h77; bus_stall = 1'b0;
        tick();
        chk("nst_t2", 32'(t_cycle), 2);
        tick();
        chk("nst_mdi_held", 32'(mem_data_in), 32'h11);
        tick();
`endif
        chk("st_end_t0", 32'(t_cycle), 0);
        // Reset in T1 of a read
        mem_enable = 1'b1; mem_write = 1'b0; mem_addr = 16'h4444; bus_rdata = 8'hAB;
        tick();
        chk("mr_t1_rd", 32'(bus_rd), 1);
        reset = 1'b0; mem_enable = 1'b0;
        tick();
        chk("mr_rd", 32'(bus_rd), 0);
        chk("mr_t", 32'(t_cycle), 0);
        chk("mr_mdi", 32'(mem_data_in), 0);
        chk("mr_addr", 32'(bus_addr), 0);
        reset = 1'b1;
        tick();
        chk("mr_rel_t", 32'(t_cycle), 1);
        chk("mr_rel_rd", 32'(bus_rd), 0);
        tick();
        tick();
        chk("mr_rel_mdi", 32'(mem_data_in), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_bus_sequencer.md
# cpu_bus_sequencer

T-cycle sequencer and memory bus interface for the CPU core. Generates the free-running 2-bit `t_cycle` count that paces the microcoded control unit, captures the control unit's per-M-cycle memory request, and drives the external 16-bit address / 8-bit data bus with read and write strobes. Returns read data as `mem_data_in`, held stable through T3 so the control unit can dispatch on it at the M-cycle boundary. Sits between the CPU control/datapath and the system bus arbiter.

## Interface
Parameters: none.

- `clk` input 1: CPU clock, one T-cycle per rising edge.
- `reset` input 1: synchronous reset, active-low (0 = reset), sampled on rising `clk`.
- `mem_enable` input 1: control unit requests a memory access this M-cycle.
- `mem_write` input 1: access is a write (valid only with `mem_enable`).
- `mem_addr` input 16: access address from datapath address mux.
- `mem_wdata` input 8: write data from datapath.
- `t_cycle` output 2: current T-cycle, 0..3.
- `mcycle_last` output 1: high while `t_cycle == 3`.
- `mem_data_in` output 8: last captured read data, to control unit and datapath.
- `bus_addr` output 16: external bus address.
- `bus_wdata` output 8: external bus write data.
- `bus_rd` output 1: external read strobe.
- `bus_wr` output 1: external write strobe.
- `bus_rdata` input 8: external read data.
- `bus_stall` input 1: bus holder requests extension of T2 (see Configuration).

## Operation
- `t_cycle` counter: 0→1→2→3→0, one step per edge; wraps 3→0 with no idle gap.
- Request capture: on the edge where `t_cycle == 0`, register `req_en = mem_enable`, `req_wr = mem_write`; if `mem_enable`, also register `mem_addr` into `bus_addr` and `mem_wdata` into `bus_wdata`. If `mem_enable == 0`, `bus_addr`/`bus_wdata` hold their previous values.
- Request inputs are ignored in T1..T3; mid-M-cycle changes have no effect.
- Read M-cycle (`req_en && !req_wr`): `bus_rd` high during T1 and T2. On the edge ending T2 (stall released), `bus_rdata` is captured into `mem_data_in`.
- Write M-cycle (`req_en && req_wr`): `bus_wr` high during T2 only; `bus_wdata` stable T1..T3.
- Idle M-cycle: `bus_rd = bus_wr = 0`; `mem_data_in` unchanged.
- `mem_data_in` changes only on a read capture; held across writes, idle cycles, and stalls.
- `bus_rd` and `bus_wr` are never high in the same cycle; both are registered-state decodes with no combinational path from `mem_*` inputs.

## Timing
- Read latency: request sampled at end of T0; data visible on `mem_data_in` at start of T3, one cycle before the control unit's T3 state update.
- Stall: if `t_cycle == 2`, `req_en == 1` and `bus_stall == 1` at an edge, `t_cycle` stays 2, strobes stay asserted, and no capture occurs. The first T2 edge with `bus_stall == 0` advances to 3 and captures (reads). `bus_stall` is ignored in T0, T1, T3 and in idle M-cycles.
- Reset (`reset == 0` at edge): `t_cycle = 0`, `req_en = 0`, `req_wr = 0`, `bus_addr = 16'h0000`, `bus_wdata = 8'h00`, `mem_data_in = 8'h00`; hence `bus_rd = bus_wr = 0`, `mcycle_last = 0`. Reset mid-access aborts it: strobes drop on that edge and no capture occurs. The first M-cycle after reset release begins at T0.

## Configuration
- `CPU_BUS_STALL_EN` defined: `bus_stall` is honoured as described in Timing.
- Not defined: `bus_stall` is ignored. `t_cycle` advances unconditionally every edge, and every M-cycle is exactly 4 clocks. The port remains present.

## Test plan
- Reset and count: hold `reset = 0` for 3 clocks, then release. Outputs match the reset values above, and `t_cycle` reads 0,1,2,3,0,1 on successive edges with `mcycle_last` high only at 3.
- Read: at T0, `mem_enable = 1`, `mem_write = 0`, `mem_addr = 16'hC123`, `bus_rdata = 8'h5A`. Expect `bus_addr = C123`, `bus_rd` high for T1 and T2, `mem_data_in = 5A` in T3, held through a following idle M-cycle.
- Write: at T0, `mem_write = 1`, `mem_addr = 16'hFF40`, `mem_wdata = 8'h91`. Expect `bus_wr` high only in T2, `bus_wdata = 91`, `bus_rd` low throughout, and `mem_data_in` unchanged.
- Mid-cycle change: toggle `mem_enable`/`mem_addr` during T1..T3. Bus outputs are unaffected until the next T0 capture.
- Stall (`CPU_BUS_STALL_EN`): on a read, hold `bus_stall = 1` for 3 edges in T2, then change `bus_rdata` to `8'h77` and release. `t_cycle` holds at 2 for 3 extra clocks, and `mem_data_in = 77` at T3. Without the macro, the same stimulus gives no stretch.
- Reset mid-read: assert `reset = 0` at T1 of a read. Strobes drop on that edge, `mem_data_in = 00`, and `t_cycle = 0` after release.
